// File: rtl/mul_sweep_pkg.sv
// Shared types and defaults for the multiplier error sweep controller.
// Optional worst-case operand capture is enabled by MUL_ERR_SWEEP_WCASE_EN.
package mul_sweep_pkg;

    localparam int W_DEF = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/mul_err_acc.sv
// Stage 2 of the sweep: absolute error, compare against running max, accumulate.
// Worst-case operand capture is present only with MUL_ERR_SWEEP_WCASE_EN.
module mul_err_acc
    import mul_sweep_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_v,
    input  logic [2*W-1:0]   i_p,
    input  logic [2*W-1:0]   i_x,
`ifdef MUL_ERR_SWEEP_WCASE_EN
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic [W-1:0]     o_wc_a,
    output logic [W-1:0]     o_wc_b,
`endif
    output logic [2*W:0]     o_cnt,
    output logic [4*W-1:0]   o_sum,
    output logic [2*W-1:0]   o_max
);

    logic [2*W:0]   w_diff;
    logic [2*W-1:0] w_lo;
    logic [2*W-1:0] w_abs;
    logic           w_gt;

    // Bit 2W of the widened difference is the sign.
    assign w_diff = {1'b0, i_p} - {1'b0, i_x};
    assign w_lo   = w_diff[2*W-1:0];
    assign w_abs  = w_diff[2*W] ? (~w_lo + 1'b1) : w_lo;
    assign w_gt   = (w_abs > o_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt <= '0;
            o_sum <= '0;
            o_max <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
            o_sum <= '0;
            o_max <= '0;
        end else if (i_v) begin
            if (w_abs != '0) begin
                o_cnt <= o_cnt + 1'b1;
            end
            o_sum <= o_sum + {{(2*W){1'b0}}, w_abs};
            if (w_gt) begin
                o_max <= w_abs;
            end
        end
    end

`ifdef MUL_ERR_SWEEP_WCASE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wc_a <= '0;
            o_wc_b <= '0;
        end else if (i_clr) begin
            o_wc_a <= '0;
            o_wc_b <= '0;
        end else if (i_v && w_gt) begin
            o_wc_a <= i_a;
            o_wc_b <= i_b;
        end
    end
`endif

endmodule

// File: rtl/mul_err_sweep_ctrl.sv
// Exhaustive operand sweep of a multiplier under test with error statistics.
// Define MUL_ERR_SWEEP_WCASE_EN to add worst-case operand outputs wc_a/wc_b.
module mul_err_sweep_ctrl
    import mul_sweep_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_p,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
`ifdef MUL_ERR_SWEEP_WCASE_EN
    output logic [W-1:0]     wc_a,
    output logic [W-1:0]     wc_b,
`endif
    output logic [2*W:0]     err_cnt,
    output logic [4*W-1:0]   err_sum,
    output logic [2*W-1:0]   err_max
);

    sweep_state_t   r_state;
    logic [2*W-1:0] r_ab;
    logic           r_drn;
    logic           r_busy;
    logic           r_done;
    logic           r_res_valid;

    logic [2*W-1:0] r_s1_p;
    logic [2*W-1:0] r_s1_x;
    logic           r_s1_v;
`ifdef MUL_ERR_SWEEP_WCASE_EN
    logic [W-1:0]   r_s1_a;
    logic [W-1:0]   r_s1_b;
`endif

    logic           w_go;
    logic [2*W-1:0] w_x;

    assign mul_a     = r_ab[2*W-1:W];
    assign mul_b     = r_ab[W-1:0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign res_valid = r_res_valid;

    assign w_go = (r_state == S_IDLE) && start && !abort;
    assign w_x  = (2*W)'(mul_a) * (2*W)'(mul_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ab        <= '0;
            r_drn       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state     <= S_RUN;
                        r_ab        <= '0;
                        r_busy      <= 1'b1;
                        r_res_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (&r_ab) begin
                        r_state <= S_DRAIN;
                        r_drn   <= 1'b0;
                    end else begin
                        r_ab <= r_ab + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_drn) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_drn <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stage 1 captures the returned product beside the exact one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_p <= '0;
            r_s1_x <= '0;
            r_s1_v <= 1'b0;
        end else begin
            r_s1_p <= mul_p;
            r_s1_x <= w_x;
            r_s1_v <= (r_state == S_RUN) && !abort;
        end
    end

`ifdef MUL_ERR_SWEEP_WCASE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_a <= '0;
            r_s1_b <= '0;
        end else begin
            r_s1_a <= mul_a;
            r_s1_b <= mul_b;
        end
    end
`endif

    mul_err_acc #(
        .W(W)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_go),
        .i_v    (r_s1_v),
        .i_p    (r_s1_p),
        .i_x    (r_s1_x),
`ifdef MUL_ERR_SWEEP_WCASE_EN
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .o_wc_a (wc_a),
        .o_wc_b (wc_b),
`endif
        .o_cnt  (err_cnt),
        .o_sum  (err_sum),
        .o_max  (err_max)
    );

endmodule

// File: doc/mul_err_sweep_ctrl.md
MUL_ERR_SWEEP_CTRL -- requirements
Module: mul_err_sweep_ctrl

Interface
REQ-001 SHALL have parameter W, default 6, meaning operand width of the multiplier under test.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have ports as follows (clock and reset first):
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep when idle.
- abort  in  1  cancel sweep.
- mul_a  out  W  operand A driven to the multiplier under test.
- mul_b  out  W  operand B driven to the multiplier under test.
- mul_p  in  2W  combinational product returned for the current mul_a/mul_b.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when results are final.
- res_valid  out  1  results hold a completed sweep.
- err_cnt  out  2W+1  number of pairs with mul_p != exact product.
- err_sum  out  4W  sum of absolute errors.
- err_max  out  2W  largest absolute error.

Function
REQ-004 SHALL implement states IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start=1 and abort=0.
- RUN->DRAIN after pair (2^W-1, 2^W-1) is presented.
- DRAIN lasts exactly 2 cycles, then ->DONE.
- DONE lasts 1 cycle, then ->IDLE.
REQ-005 SHALL, on entering RUN, clear all accumulators and res_valid, and set mul_a=mul_b=0.
REQ-006 SHALL present one pair per RUN cycle: mul_b increments each cycle, and on wrap from 2^W-1 to 0 mul_a increments (all 2^(2W) pairs, mul_b fastest).
REQ-007 SHALL register mul_p together with the exact product mul_a*mul_b in the same cycle the pair is presented (stage 1).
REQ-008 SHALL compute abs error from stage 1 using a 2W+1-bit signed difference, and update err_cnt, err_sum and err_max on the following edge (stage 2).
REQ-009 SHALL have these timing properties, with start sampled in cycle 0:
- pair i is presented in cycle i+1;
- done=1 and res_valid=1 in cycle 2^(2W)+3 (cycle 4099 for W=6).
REQ-010 SHALL drive busy=1 in RUN and DRAIN only, and done=1 in DONE only.
REQ-011 SHALL ignore start while busy or in DONE.
REQ-012 SHALL, on abort=1 in RUN or DRAIN:
- go to IDLE on the next edge;
- not assert done;
- leave res_valid=0.
REQ-013 SHALL give abort priority when start and abort are both asserted in IDLE: remain IDLE.
REQ-014 SHALL hold result outputs and res_valid stable from DONE until the next accepted start.
REQ-015 SHALL hold mul_a/mul_b at their last values outside RUN.
REQ-016 SHALL keep err_sum from wrapping for any mul_p; 4W bits suffice because the maximum error is below 2^(2W).

Reset
REQ-017 SHALL, on rst_n=0, asynchronously force:
- state IDLE;
- mul_a, mul_b, busy, done, res_valid, err_cnt, err_sum, err_max all 0;
- pipeline valid flags 0.
REQ-018 SHALL discard a sweep in progress when reset is asserted mid-sweep, and start no sweep after release until start is asserted.

Configuration
REQ-019 SHALL, with macro MUL_ERR_SWEEP_WCASE_EN defined:
- add outputs wc_a (W) and wc_b (W), reset 0;
- capture the operands of the first pair whose error strictly exceeds the running err_max;
- on a zero-error sweep, wc_a=wc_b=0.
REQ-020 SHALL, without MUL_ERR_SWEEP_WCASE_EN, omit wc_a/wc_b and their logic entirely.

Structure
REQ-021 SHALL place the state enum and the default W in shared package mul_sweep_pkg.
REQ-022 SHALL implement stage 2 (abs error, compare, accumulate) as sub-module mul_err_acc.

Verification
REQ-023 SHALL cover these directed scenarios (W=6):
- Exact stub (mul_p=a*b), start at cycle 0 -> done at cycle 4099; err_cnt=0, err_sum=0, err_max=0, res_valid=1.
- Zero stub (mul_p=0) -> err_cnt=3969, err_sum=4064256, err_max=3969; with MUL_ERR_SWEEP_WCASE_EN, wc_a=63, wc_b=63.
- LSB-cleared stub (mul_p=a*b & ~1) -> err_cnt=1024, err_sum=1024, err_max=1.
- Abort in cycle 100 -> busy=0 from cycle 101, no done pulse, res_valid=0; a following start completes normally.
- start pulsed during RUN and in the DONE cycle -> ignored; done pulses exactly once, 4099 cycles after the first start.
- rst_n asserted in cycle 2000 -> all outputs 0 immediately, state IDLE, no done after release.
